// File: rtl/dsp_mac_pkg.sv
// Shared constants for the MAC pipeline: pre-adder mode encodings and
// default operand/accumulator widths.
package dsp_mac_pkg;

    localparam int DEF_AW      = 18;
    localparam int DEF_BW      = 18;
    localparam int DEF_PW      = 48;
    localparam int DEF_ACC_LEN = 4;

    // Pre-adder select. Both 00 and 11 pass B straight through.
    typedef enum logic [1:0] {
        MODE_B     = 2'b00,
        MODE_DPB   = 2'b01,
        MODE_DMB   = 2'b10,
        MODE_B_ALT = 2'b11
    } mode_e;

endpackage

// File: rtl/dsp_sat_add.sv
// PW-bit signed adder with overflow detect. On overflow it either clamps
// to the signed range limit in the direction of the true sum, or wraps.
module dsp_sat_add #(
    parameter int PW     = 48,
    parameter int SAT_EN = 1
) (
    input  logic signed [PW-1:0] a_i,
    input  logic signed [PW-1:0] b_i,
    output logic signed [PW-1:0] sum_o,
    output logic                 ovf_o
);

    localparam logic signed [PW-1:0] MAX_VAL = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_VAL = {1'b1, {(PW-1){1'b0}}};

    logic signed [PW:0] wide;

    assign wide = {a_i[PW-1], a_i} + {b_i[PW-1], b_i};

    // Overflow when the extra sign bit disagrees with the PW-bit result sign.
    always_comb begin
        ovf_o = wide[PW] ^ wide[PW-1];
        sum_o = wide[PW-1:0];
        if (ovf_o && (SAT_EN != 0)) begin
            sum_o = wide[PW] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Three-stage pre-add / multiply / accumulate pipeline. A window of
// ACC_LEN valid samples is summed; the window total appears on P with a
// one-cycle P_VALID strobe. OVF is sticky until RST or CLR.
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int BW      = DEF_BW,
    parameter int PW      = DEF_PW,
    parameter int ACC_LEN = DEF_ACC_LEN,
    parameter int SAT_EN  = 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             CE,
    input  logic                             CLR,
    input  logic                             IN_VALID,
    input  logic [1:0]                       MODE,
    input  logic signed [AW-1:0]             A,
    input  logic signed [BW-1:0]             B,
    input  logic signed [BW-1:0]             D,
    output logic signed [PW-1:0]             P,
    output logic                             P_VALID,
    output logic                             OVF,
    output logic [$clog2(ACC_LEN+1)-1:0]     CNT
);

    localparam int PRW = AW + BW + 1;
    localparam int CW  = $clog2(ACC_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(ACC_LEN - 1);

    if (AW + BW + 1 > PW) begin : g_bad_pw
        $error("dsp_mac_pipe: PW must be at least AW+BW+1");
    end
    if (ACC_LEN < 1) begin : g_bad_len
        $error("dsp_mac_pipe: ACC_LEN must be at least 1");
    end

    logic signed [AW-1:0]  a1_q, a1_d;
    logic signed [BW:0]    pre1_q, pre1_d;
    logic                  v1_q, v1_d;
    logic signed [PW-1:0]  prod2_q, prod2_d;
    logic                  v2_q, v2_d;
    logic signed [PW-1:0]  acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic signed [PW-1:0]  p_q, p_d;
    logic                  p_valid_q, p_valid_d;

    logic signed [BW:0]    b_ext, d_ext, pre_sum;
    logic signed [PRW-1:0] prod_full;
    logic signed [PW-1:0]  add_a, add_sum;
    logic                  add_ovf;
    logic                  first_smp, last_smp;

    assign b_ext = {B[BW-1], B};
    assign d_ext = {D[BW-1], D};

    // Pre-adder, one bit wider than the operands so D+B / D-B never wrap.
    always_comb begin
        case (MODE)
            MODE_DPB: pre_sum = d_ext + b_ext;
            MODE_DMB: pre_sum = d_ext - b_ext;
            default:  pre_sum = b_ext;
        endcase
    end

    assign prod_full = PRW'(a1_q) * PRW'(pre1_q);

    // Sample 1 of a window loads the product rather than adding to stale acc.
    assign first_smp = (cnt_q == '0);
    assign last_smp  = (cnt_q == LAST_IDX);
    assign add_a     = first_smp ? '0 : acc_q;

    dsp_sat_add #(
        .PW     (PW),
        .SAT_EN (SAT_EN)
    ) u_sat_add (
        .a_i   (add_a),
        .b_i   (prod2_q),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // Next-state: CLR beats CE; P_VALID only rises on an enabled last sample.
    always_comb begin
        a1_d      = a1_q;
        pre1_d    = pre1_q;
        v1_d      = v1_q;
        prod2_d   = prod2_q;
        v2_d      = v2_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        p_d       = p_q;
        p_valid_d = 1'b0;
        if (CLR) begin
            v1_d  = 1'b0;
            v2_d  = 1'b0;
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (CE) begin
            a1_d    = A;
            pre1_d  = pre_sum;
            v1_d    = IN_VALID;
            prod2_d = PW'(prod_full);
            v2_d    = v1_q;
            if (v2_q) begin
                acc_d = add_sum;
                ovf_d = ovf_q | add_ovf;
                if (last_smp) begin
                    cnt_d     = '0;
                    p_d       = add_sum;
                    p_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Pipeline, accumulator and result registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a1_q      <= '0;
            pre1_q    <= '0;
            v1_q      <= 1'b0;
            prod2_q   <= '0;
            v2_q      <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
        end else begin
            a1_q      <= a1_d;
            pre1_q    <= pre1_d;
            v1_q      <= v1_d;
            prod2_q   <= prod2_d;
            v2_q      <= v2_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
        end
    end

    assign P       = p_q;
    assign P_VALID = p_valid_q;
    assign OVF     = ovf_q;
    assign CNT     = cnt_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: three instances (ACC_LEN=4, ACC_LEN=1,
// narrow saturating ACC_LEN=16) share clock, reset and control inputs.
module tb_dsp_mac_pipe;

    logic        CLK = 1'b0;
    logic        RST, CE, CLR, IN_VALID;
    logic [1:0]  MODE;
    logic [17:0] A, B, D;
    logic [7:0]  A8, B8, D8;

    logic [47:0] p4;  logic pv4; logic ovf4; logic [2:0] cnt4;
    logic [47:0] p1;  logic pv1; logic ovf1; logic [0:0] cnt1;
    logic [17:0] p8;  logic pv8; logic ovf8; logic [4:0] cnt8;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .ACC_LEN(4), .SAT_EN(1)) u4 (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .IN_VALID(IN_VALID),
        .MODE(MODE), .A(A), .B(B), .D(D),
        .P(p4), .P_VALID(pv4), .OVF(ovf4), .CNT(cnt4));

    dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .ACC_LEN(1), .SAT_EN(1)) u1 (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .IN_VALID(IN_VALID),
        .MODE(MODE), .A(A), .B(B), .D(D),
        .P(p1), .P_VALID(pv1), .OVF(ovf1), .CNT(cnt1));

    dsp_mac_pipe #(.AW(8), .BW(8), .PW(18), .ACC_LEN(16), .SAT_EN(1)) u8 (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .IN_VALID(IN_VALID),
        .MODE(MODE), .A(A8), .B(B8), .D(D8),
        .P(p8), .P_VALID(pv8), .OVF(ovf8), .CNT(cnt8));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; CE = 1'b1; CLR = 1'b0; IN_VALID = 1'b0;
        #2;
        RST = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        MODE = 2'b01; A = 18'd3; B = 18'd2; D = 18'd5;
        for (int t = 1; t <= 3; t++) begin
            IN_VALID = 1'b1;
            tick();
        end
        IN_VALID = 1'b0;
        checks++; if (cnt4 !== 3'd1) begin errors++; $display("FAIL pre_rst_cnt: got %0d want 1", cnt4); end
        checks++; if (p1 !== 48'd21) begin errors++; $display("FAIL pre_rst_p1: got %0d want 21", $signed(p1)); end
        RST = 1'b1;
        #2;
        checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", cnt4); end
        checks++; if (p4 !== 48'd0) begin errors++; $display("FAIL rst_p: got %0d want 0", p4); end
        checks++; if (pv4 !== 1'b0) begin errors++; $display("FAIL rst_pvalid: got %0b want 0", pv4); end
        checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b want 0", ovf4); end
        checks++; if (p1 !== 48'd0 || pv1 !== 1'b0) begin errors++; $display("FAIL rst_p1: got p=%0d v=%0b want 0 0", p1, pv1); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_window();
        int n = 0;
        int st[2];
        logic [47:0] ps[2];
        do_reset();
        MODE = 2'b01; B = 18'd2; D = 18'd5;
        for (int t = 1; t <= 14; t++) begin
            IN_VALID = (t <= 8);
            A = (t <= 4) ? 18'd3 : 18'd1;
            tick();
            if (t == 5) begin
                checks++; if (cnt4 !== 3'd3) begin errors++; $display("FAIL win_cnt_mid: got %0d want 3", cnt4); end
            end
            if (t == 6) begin
                checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL win_cnt_wrap: got %0d want 0", cnt4); end
            end
            if (pv4 === 1'b1) begin
                if (n < 2) begin st[n] = t; ps[n] = p4; end
                n++;
            end
        end
        IN_VALID = 1'b0;
        checks++; if (n != 2) begin errors++; $display("FAIL win_strobes: got %0d want 2", n); end
        if (n >= 2) begin
            checks++; if (st[0] != 6) begin errors++; $display("FAIL win1_tick: got %0d want 6", st[0]); end
            checks++; if (ps[0] !== 48'd84) begin errors++; $display("FAIL win1_p: got %0d want 84", $signed(ps[0])); end
            checks++; if (st[1] != 10) begin errors++; $display("FAIL win2_tick: got %0d want 10", st[1]); end
            checks++; if (ps[1] !== 48'd28) begin errors++; $display("FAIL win2_p: got %0d want 28", $signed(ps[1])); end
        end
        checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL win_ovf: got %0b want 0", ovf4); end
    endtask

    task automatic test_acclen1();
        logic        exp_v;
        logic [47:0] exp_p;
        do_reset();
        MODE = 2'b10; B = 18'd4; D = 18'd1;
        for (int t = 1; t <= 8; t++) begin
            IN_VALID = (t <= 5);
            A = (t == 5) ? 18'd2 : 18'd5;
            tick();
            exp_v = (t >= 3 && t <= 7);
            exp_p = (t == 7) ? -48'sd6 : -48'sd15;
            checks++; if (pv1 !== exp_v) begin errors++; $display("FAIL len1_pv t=%0d: got %0b want %0b", t, pv1, exp_v); end
            if (exp_v) begin
                checks++; if (p1 !== exp_p) begin errors++; $display("FAIL len1_p t=%0d: got %0d want %0d", t, $signed(p1), $signed(exp_p)); end
            end
        end
        IN_VALID = 1'b0;
        checks++; if (cnt1 !== 1'b0 || ovf1 !== 1'b0) begin errors++; $display("FAIL len1_cnt_ovf: got %0d %0b want 0 0", cnt1, ovf1); end
    endtask

    task automatic test_saturate();
        int n = 0;
        int st = 0;
        logic [17:0] ps = '0;
        do_reset();
        MODE = 2'b00; A8 = 8'd127; B8 = 8'd127; D8 = 8'd0;
        for (int t = 1; t <= 20; t++) begin
            IN_VALID = (t <= 16);
            tick();
            if (t == 10) begin
                checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL sat_ovf8: got %0b want 0", ovf8); end
            end
            if (t == 11) begin
                checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL sat_ovf9: got %0b want 1", ovf8); end
                checks++; if (p8 !== 18'd0) begin errors++; $display("FAIL sat_p_hold: got %0d want 0", p8); end
            end
            if (pv8 === 1'b1) begin
                if (n == 0) begin st = t; ps = p8; end
                n++;
            end
        end
        IN_VALID = 1'b0;
        checks++; if (n != 1 || st != 18) begin errors++; $display("FAIL sat_strobe: got n=%0d tick=%0d want 1 18", n, st); end
        checks++; if (ps !== 18'd131071) begin errors++; $display("FAIL sat_p: got %0d want 131071", ps); end
        checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL sat_ovf_end: got %0b want 1", ovf8); end
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL sat_clr_ovf: got %0b want 0", ovf8); end
        checks++; if (p8 !== 18'd131071) begin errors++; $display("FAIL sat_clr_p: got %0d want 131071", p8); end
    endtask

    task automatic test_ce_stall();
        int n = 0;
        int st = 0;
        logic [47:0] ps = '0;
        do_reset();
        MODE = 2'b01; A = 18'd3; B = 18'd2; D = 18'd5;
        for (int t = 1; t <= 12; t++) begin
            CE = !(t == 3 || t == 4);
            IN_VALID = (t <= 6);
            tick();
            if (pv4 === 1'b1) begin
                if (n == 0) begin st = t; ps = p4; end
                n++;
            end
        end
        CE = 1'b1; IN_VALID = 1'b0;
        checks++; if (n != 1) begin errors++; $display("FAIL stall_strobes: got %0d want 1", n); end
        checks++; if (st != 8) begin errors++; $display("FAIL stall_tick: got %0d want 8", st); end
        checks++; if (ps !== 48'd84) begin errors++; $display("FAIL stall_p: got %0d want 84", $signed(ps)); end

        do_reset();
        n = 0; st = 0;
        for (int t = 1; t <= 12; t++) begin
            CE = !(t == 6 || t == 8);
            IN_VALID = (t <= 4);
            tick();
            if (t == 6 || t == 8) begin
                checks++; if (pv4 !== 1'b0) begin errors++; $display("FAIL ce0_pv t=%0d: got %0b want 0", t, pv4); end
            end
            if (pv4 === 1'b1) begin
                if (n == 0) st = t;
                n++;
            end
        end
        CE = 1'b1; IN_VALID = 1'b0;
        checks++; if (n != 1 || st != 7) begin errors++; $display("FAIL ce0_strobe: got n=%0d tick=%0d want 1 7", n, st); end
        checks++; if (p4 !== 48'd84) begin errors++; $display("FAIL ce0_p: got %0d want 84", $signed(p4)); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int st = 0;
        logic [47:0] ps = '0;
        do_reset();
        MODE = 2'b01; A = 18'd100; B = 18'd2; D = 18'd5;
        for (int t = 1; t <= 3; t++) begin
            IN_VALID = (t <= 2);
            tick();
        end
        checks++; if (cnt4 !== 3'd1) begin errors++; $display("FAIL rmid_cnt_pre: got %0d want 1", cnt4); end
        RST = 1'b1;
        #2;
        RST = 1'b0;
        checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", cnt4); end
        A = 18'd3;
        for (int t = 1; t <= 10; t++) begin
            IN_VALID = (t <= 4);
            tick();
            if (pv4 === 1'b1) begin
                if (n == 0) begin st = t; ps = p4; end
                n++;
            end
        end
        IN_VALID = 1'b0;
        checks++; if (n != 1 || st != 6) begin errors++; $display("FAIL rmid_strobe: got n=%0d tick=%0d want 1 6", n, st); end
        checks++; if (ps !== 48'd84) begin errors++; $display("FAIL rmid_p: got %0d want 84", $signed(ps)); end
    endtask

    task automatic test_clr();
        int n = 0;
        int st = 0;
        logic [47:0] ps = '0;
        do_reset();
        MODE = 2'b01; A = 18'd1; B = 18'd2; D = 18'd5;
        for (int t = 1; t <= 8; t++) begin
            IN_VALID = (t <= 4);
            CLR = (t == 6);
            tick();
            if (t == 6) begin
                checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", cnt4); end
                checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %0b want 0", ovf4); end
                checks++; if (p4 !== 48'd0) begin errors++; $display("FAIL clr_p_hold: got %0d want 0", $signed(p4)); end
            end
            if (pv4 === 1'b1) n++;
        end
        CLR = 1'b0;
        checks++; if (n != 0) begin errors++; $display("FAIL clr_strobe: got %0d want 0", n); end
        A = 18'd3;
        for (int t = 1; t <= 10; t++) begin
            IN_VALID = (t <= 4);
            tick();
            if (pv4 === 1'b1) begin
                if (n == 0) begin st = t; ps = p4; end
                n++;
            end
        end
        IN_VALID = 1'b0;
        checks++; if (n != 1 || st != 6) begin errors++; $display("FAIL clr_next_strobe: got n=%0d tick=%0d want 1 6", n, st); end
        checks++; if (ps !== 48'd84) begin errors++; $display("FAIL clr_next_p: got %0d want 84", $signed(ps)); end
    endtask

    initial begin
        RST = 1'b1; CE = 1'b1; CLR = 1'b0; IN_VALID = 1'b0;
        MODE = 2'b00; A = '0; B = '0; D = '0; A8 = '0; B8 = '0; D8 = '0;
        #12;
        RST = 1'b0;
        tick();
        test_reset();
        test_window();
        test_acclen1();
        test_saturate();
        test_ce_stall();
        test_reset_mid();
        test_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
